// File: rtl/dcache_axi_pkg.sv
// rtl/dcache_axi_pkg.sv - shared types and constants for the dcache AXI write-burst bridge
package dcache_axi_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int LEN_W  = 8;
    localparam int FIFO_W = DATA_W + STRB_W + 1;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
    } wbeat_t;

endpackage

// File: rtl/dcache_axi_wfifo.sv
// rtl/dcache_axi_wfifo.sv - two-entry W-beat buffer between the cache port and AXI W
module dcache_axi_wfifo
    import dcache_axi_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [FIFO_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [FIFO_W-1:0] pop_data_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [FIFO_W-1:0] entry0_q;
    logic [FIFO_W-1:0] entry1_q;
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              push_ok;
    logic              pop_ok;

    assign full_o     = (count_q == 2'd2);
    assign empty_o    = (count_q == 2'd0);
    assign push_ok    = push_i & ~full_o;
    assign pop_ok     = pop_i & ~empty_o;
    assign pop_data_o = rd_ptr_q ? entry1_q : entry0_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entry0_q <= '0;
            entry1_q <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                if (wr_ptr_q) begin
                    entry1_q <= push_data_i;
                end else begin
                    entry0_q <= push_data_i;
                end
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + 2'd1;
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - 2'd1;
            end
        end
    end

endmodule

// File: rtl/dcache_axi_wburst.sv
// rtl/dcache_axi_wburst.sv - turns a beat-at-a-time cache write port into one AXI INCR write burst
module dcache_axi_wburst
    import dcache_axi_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              inport_valid_i,
    input  logic              inport_write_i,
    input  logic [ADDR_W-1:0] inport_addr_i,
    input  logic [LEN_W-1:0]  inport_len_i,
    input  logic [DATA_W-1:0] inport_wdata_i,
    input  logic [STRB_W-1:0] inport_wstrb_i,
    output logic              inport_accept_o,
    output logic              inport_ack_o,
    output logic              inport_error_o,
    output logic              outport_awvalid_o,
    input  logic              outport_awready_i,
    output logic [ADDR_W-1:0] outport_awaddr_o,
    output logic [LEN_W-1:0]  outport_awlen_o,
    output logic [1:0]        outport_awburst_o,
    output logic              outport_wvalid_o,
    input  logic              outport_wready_i,
    output logic [DATA_W-1:0] outport_wdata_o,
    output logic [STRB_W-1:0] outport_wstrb_o,
    output logic              outport_wlast_o,
    input  logic              outport_bvalid_i,
    input  logic [1:0]        outport_bresp_i,
    output logic              outport_bready_o
);

    wb_state_e         state_q, state_d;
    logic [LEN_W-1:0]  req_cnt_q, req_cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic              aw_pending_q;
    logic              aw_done_q;
    logic              ack_q;
    logic              error_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_W-1:0] fifo_head;
    wbeat_t            push_beat;
    wbeat_t            head_beat;

    logic              accept;
    logic              beat_last;
    logic              first_beat;
    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;
    logic              resp_err;

    // Gated by reset so the port reads as idle while reset is held, even with a beat offered.
    assign accept = rst_ni & inport_valid_i & inport_write_i
                  & (state_q != ST_RESP) & ~fifo_full;

    assign first_beat = accept & (state_q == ST_IDLE);
    assign beat_last  = (state_q == ST_IDLE) ? (inport_len_i == '0) : (req_cnt_q <= 8'd1);

    assign aw_hs    = aw_pending_q & outport_awready_i;
    assign w_hs     = ~fifo_empty & outport_wready_i;
    assign b_hs     = outport_bvalid_i & outport_bready_o;
    assign resp_err = (outport_bresp_i == AXI_RESP_SLVERR) | (outport_bresp_i == AXI_RESP_DECERR);

    assign push_beat = '{data: inport_wdata_i, strb: inport_wstrb_i, last: beat_last};
    assign head_beat = wbeat_t'(fifo_head);

    dcache_axi_wfifo u_wfifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (accept),
        .push_data_i (push_beat),
        .pop_i       (w_hs),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        req_cnt_d = req_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_cnt_d = inport_len_i;
                    state_d   = (inport_len_i == '0) ? ST_RESP : ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    if (req_cnt_q != '0) begin
                        req_cnt_d = req_cnt_q - 8'd1;
                    end
                    if (req_cnt_q <= 8'd1) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (b_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            req_cnt_q    <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            aw_pending_q <= 1'b0;
            aw_done_q    <= 1'b0;
            ack_q        <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_cnt_q <= req_cnt_d;
            if (first_beat) begin
                addr_q       <= inport_addr_i;
                len_q        <= inport_len_i;
                aw_pending_q <= 1'b1;
            end else if (aw_hs) begin
                aw_pending_q <= 1'b0;
            end
            // Response is only taken once the address phase has completed.
            if (aw_hs) begin
                aw_done_q <= 1'b1;
            end else if (b_hs) begin
                aw_done_q <= 1'b0;
            end
            ack_q   <= b_hs;
            error_q <= b_hs & resp_err;
        end
    end

    assign inport_accept_o   = accept;
    assign inport_ack_o      = ack_q;
    assign inport_error_o    = error_q;
    assign outport_awvalid_o = aw_pending_q;
    assign outport_awaddr_o  = addr_q;
    assign outport_awlen_o   = len_q;
    assign outport_awburst_o = AXI_BURST_INCR;
    assign outport_wvalid_o  = ~fifo_empty;
    assign outport_wdata_o   = head_beat.data;
    assign outport_wstrb_o   = head_beat.strb;
    assign outport_wlast_o   = head_beat.last;
    assign outport_bready_o  = (state_q == ST_RESP) & aw_done_q & fifo_empty;

endmodule

// File: doc/dcache_axi_wburst.md
DCACHE_AXI_WBURST -- requirements
Module: dcache_axi_wburst

Interface
REQ-001 SHALL have no parameters; widths fixed: address 32, data 32, strobe 4, length 8.
REQ-002 Ports SHALL be as follows; clock and reset first.
- clk_i  in  1  single clock; all logic on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- inport_valid_i  in  1  write beat offered.
- inport_write_i  in  1  beat is a write; beats with 0 are never accepted.
- inport_addr_i  in  32  burst start address; sampled on first beat only.
- inport_len_i  in  8  AXI len (beats-1); sampled on first beat only.
- inport_wdata_i  in  32  beat data.
- inport_wstrb_i  in  4  beat byte strobes.
- inport_accept_o  out  1  beat accepted this cycle.
- inport_ack_o  out  1  one-cycle pulse on burst completion.
- inport_error_o  out  1  valid with ack; 1 = SLVERR/DECERR.
- outport_awvalid_o  out  1  AXI AW valid.
- outport_awready_i  in  1  AXI AW ready.
- outport_awaddr_o  out  32  AXI AW address.
- outport_awlen_o  out  8  AXI AW len.
- outport_awburst_o  out  2  constant INCR (2'b01).
- outport_wvalid_o  out  1  AXI W valid.
- outport_wready_i  in  1  AXI W ready.
- outport_wdata_o  out  32  AXI W data.
- outport_wstrb_o  out  4  AXI W strobes.
- outport_wlast_o  out  1  AXI W last.
- outport_bvalid_i  in  1  AXI B valid.
- outport_bresp_i  in  2  AXI B response.
- outport_bready_o  out  1  AXI B ready.

Function
REQ-003 State machine SHALL have states IDLE, DATA, RESP; one burst outstanding at a time.
REQ-004 inport_accept_o SHALL equal inport_valid_i & inport_write_i & (state != RESP) & !fifo_full, combinational.
REQ-005 In IDLE, an accepted beat SHALL latch addr and len, set AW pending, and load req_cnt_q with inport_len_i.
- len == 0: the beat is last; next state RESP.
- len != 0: next state DATA.
REQ-006 In DATA, each accepted beat SHALL decrement req_cnt_q by 1.
- The beat accepted with req_cnt_q == 1 is last; next state RESP.
- req_cnt_q SHALL never wrap below 0.
REQ-007 Accepted beats SHALL be pushed as {data, strb, last} into a 2-entry FIFO.
- W outputs SHALL be driven from the FIFO head; wvalid_o = !fifo_empty.
- Pop on wvalid & wready.
- Same-cycle push and pop when full SHALL NOT be allowed, since accept depends on !full.
REQ-008 outport_awvalid_o SHALL rise the cycle after first-beat acceptance and hold until awready.
- awaddr and awlen SHALL be stable while valid.
- W beats MAY precede AW completion.
REQ-009 outport_bready_o SHALL be 1 only in RESP with AW done and FIFO empty.
REQ-010 On bvalid & bready, the block SHALL:
- pulse inport_ack_o for one cycle next edge;
- set inport_error_o = bresp[1];
- return to IDLE.
REQ-011 A beat SHALL be accepted in the same cycle the B handshake occurs only from IDLE, i.e. never (RESP blocks acceptance).
REQ-012 bvalid arriving outside RESP SHALL be ignored, with bready held low.

Reset
REQ-013 On rst_ni low, asynchronously:
- state = IDLE;
- req_cnt_q = 0;
- FIFO empty;
- AW pending clear;
- awvalid, wvalid, bready, accept, ack and error all 0;
- latched addr and len = 0.
REQ-014 Reset asserted mid-burst SHALL abandon the burst with no ack; the first post-reset accepted beat is treated as a new first beat.

Structure
REQ-015 Package dcache_axi_pkg SHALL hold:
- the state enum;
- AXI_BURST_INCR = 2'b01;
- AXI_RESP_OKAY, AXI_RESP_SLVERR, AXI_RESP_DECERR;
- widths ADDR_W = 32, DATA_W = 32, LEN_W = 8.
REQ-016 The 2-entry FIFO SHALL be sub-module dcache_axi_wfifo (37-bit entries, full/empty flags, same reset).

Verification
REQ-017 Single beat:
- Stimulus: addr 0x1000, len 0, data 0xDEADBEEF, all readies 1.
- Response: AW {0x1000, 0, INCR}; one W with wlast = 1; bresp OKAY gives ack = 1, error = 0.
REQ-018 Burst of 4:
- Stimulus: len 3, data 1..4.
- Response: req_cnt_q 3→2→1→0; wlast only on data 4; exactly one AW.
REQ-019 Backpressure:
- Stimulus: wready = 0 for 5 cycles during a len-7 burst.
- Response: accept drops after 2 buffered beats; no beat lost or reordered.
REQ-020 AW late:
- Stimulus: awready held 0 until all 4 W beats complete.
- Response: bready stays 0 until AW handshakes; then completes.
REQ-021 Error response:
- Stimulus: bresp = 2'b10.
- Response: ack = 1, error = 1; next burst accepted from IDLE.
REQ-022 Reset mid-burst:
- Stimulus: rst_ni low after 2 of 4 beats.
- Response: all outputs 0 immediately; new len 0 burst then completes normally.
